// File: rtl/div_radix2_pkg.sv
// Shared definitions for the radix-2 restoring divider: state encodings,
// handshake levels, result field positions and the operand magnitude helper.
package div_radix2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_DIVZERO = 2'b01,
    ST_BUSY    = 2'b10,
    ST_END     = 2'b11
  } div_state_t;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  localparam int RemMsb = 63;
  localparam int RemLsb = 32;
  localparam int QuoMsb = 31;
  localparam int QuoLsb = 0;

  function automatic logic [31:0] abs_word(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? -v : v;
  endfunction

endpackage

// File: rtl/div_radix2_if.sv
// EX <-> divider handshake bundle. EX is the master (drives operands and
// start/annul), the divider is the slave (returns result/ready).
interface div_radix2_if;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div_restore_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor if it fits.
module div_restore_step (
  input  logic [31:0] rem,
  input  logic        dvd_bit,
  input  logic [31:0] divisor,
  output logic [31:0] rem_next,
  output logic        q_bit
);

  // Full 33-bit shifted remainder so divisors above 2^31 stay exact.
  logic [32:0] shifted;
  logic [33:0] diff;

  assign shifted  = {rem, dvd_bit};
  assign diff     = {1'b0, shifted} - {2'b00, divisor};
  assign q_bit    = ~diff[33];
  assign rem_next = q_bit ? diff[31:0] : shifted[31:0];

endmodule

// File: rtl/div_radix2.sv
// Iterative radix-2 restoring divider, one quotient bit per cycle.
// Optional DIV_EARLY_OUT_EN: skip iterations when |dividend| < |divisor|.
module div_radix2
  import div_radix2_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic         clk,
  input  logic         resetn,
  div_radix2_if.slave  bus
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH);

  div_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dsr;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic             neg_dvd;
  logic             neg_dsr;
  logic [63:0]      result_r;
  logic             ready_r;

  logic [WIDTH-1:0] rem_next;
  logic             q_bit;
  logic [WIDTH-1:0] abs1;
  logic [WIDTH-1:0] abs2;

  assign abs1 = abs_word(bus.opdata1_i, bus.signed_div_i);
  assign abs2 = abs_word(bus.opdata2_i, bus.signed_div_i);

  div_restore_step u_step (
    .rem      (rem),
    .dvd_bit  (dvd[WIDTH-1]),
    .divisor  (dsr),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  assign bus.result_o = result_r;
  assign bus.ready_o  = ready_r;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      dvd      <= ZeroWord;
      dsr      <= ZeroWord;
      rem      <= ZeroWord;
      quo      <= ZeroWord;
      neg_dvd  <= 1'b0;
      neg_dsr  <= 1'b0;
      result_r <= '0;
      ready_r  <= DivResultNotReady;
    end else if (bus.annul_i && state != ST_IDLE) begin
      state    <= ST_IDLE;
      result_r <= '0;
      ready_r  <= DivResultNotReady;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start_i == DivStart && !bus.annul_i) begin
            if (bus.opdata2_i == ZeroWord) begin
              state <= ST_DIVZERO;
            end else begin
              state   <= ST_BUSY;
              neg_dvd <= bus.signed_div_i & bus.opdata1_i[31];
              neg_dsr <= bus.signed_div_i & bus.opdata2_i[31];
              dvd     <= abs1;
              dsr     <= abs2;
              rem     <= ZeroWord;
              quo     <= ZeroWord;
              cnt     <= '0;
`ifdef DIV_EARLY_OUT_EN
              // Quotient is zero: park the dividend magnitude as remainder and
              // jump straight to the sign-correction cycle.
              if (abs1 < abs2) begin
                rem <= abs1;
                cnt <= LastCnt;
              end
`endif
            end
          end
        end
        ST_DIVZERO: begin
          state    <= ST_END;
          result_r <= '0;
          ready_r  <= DivResultReady;
        end
        ST_BUSY: begin
          if (cnt == LastCnt) begin
            state                    <= ST_END;
            result_r[RemMsb:RemLsb]  <= neg_dvd ? -rem : rem;
            result_r[QuoMsb:QuoLsb]  <= (neg_dvd ^ neg_dsr) ? -quo : quo;
            ready_r                  <= DivResultReady;
          end else begin
            rem <= rem_next;
            quo <= {quo[WIDTH-2:0], q_bit};
            dvd <= {dvd[WIDTH-2:0], 1'b0};
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_END: begin
          if (bus.start_i == DivStop) begin
            state    <= ST_IDLE;
            result_r <= '0;
            ready_r  <= DivResultNotReady;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_radix2.sv
// Directed self-checking bench for div_radix2 with hand-computed results.
module tb_div_radix2;

  logic clk;
  logic resetn;
  int   n_pass;
  int   n_total;

  div_radix2_if bus ();

  div_radix2 dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef DIV_EARLY_OUT_EN
  localparam int EarlyLat = 2;
`else
  localparam int EarlyLat = 34;
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Start a divide, count edges until ready, check result, hold, then release.
  task automatic do_div(input string tag, input logic sg, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input logic [63:0] exp_res);
    int edges;
    @(negedge clk);
    bus.signed_div_i = sg;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
    edges = 0;
    while (bus.ready_o !== 1'b1 && edges < 60) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check({tag, "_lat"}, 64'(edges), 64'(exp_lat));
    check({tag, "_res"}, bus.result_o, exp_res);
    bus.opdata1_i = 32'h1234_5678;
    bus.opdata2_i = 32'h0000_0003;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_hold"}, {bus.result_o, 63'(0)} | 127'(bus.ready_o), {exp_res, 63'(0)} | 127'(1));
    bus.start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_drop"}, {bus.result_o[63:1], bus.result_o[0] | bus.ready_o}, 64'h0);
  endtask

  initial begin
    int rises;
    n_pass  = 0;
    n_total = 0;
    resetn  = 1'b0;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'h0;
    bus.opdata2_i    = 32'h0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(bus.ready_o), 64'h0);
    check("rst_result", bus.result_o, 64'h0);
    resetn = 1'b1;

    do_div("u100_7",   1'b0, 32'd100,        32'd7,          34,       64'h00000002_0000000E);
    do_div("s-7_2",    1'b1, 32'hFFFF_FFF9,  32'd2,          34,       64'hFFFFFFFF_FFFFFFFD);
    do_div("s5_0",     1'b1, 32'd5,          32'd0,          2,        64'h0);
    do_div("u5_0",     1'b0, 32'd5,          32'd0,          2,        64'h0);
    do_div("s_ovf",    1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  34,       64'h00000000_80000000);
    do_div("u_big",    1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  EarlyLat, 64'h80000000_00000000);
    do_div("s-3_7",    1'b1, 32'hFFFF_FFFD,  32'd7,          EarlyLat, 64'hFFFFFFFD_00000000);
    do_div("s100_-7",  1'b1, 32'd100,        32'hFFFF_FFF9,  34,       64'h00000002_FFFFFFF2);

    // Annul at BUSY iteration 10, then a fresh divide.
    @(negedge clk);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd1000;
    bus.opdata2_i    = 32'd7;
    bus.start_i      = 1'b1;
    repeat (11) @(posedge clk);
    @(negedge clk);
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.annul_i = 1'b0;
    rises = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.ready_o !== 1'b0) rises++;
    end
    check("annul_busy_noready", 64'(rises), 64'h0);
    do_div("u9_3",     1'b0, 32'd9,          32'd3,          34,       64'h00000000_00000003);

    // Annul in END overrides a still-held start.
    @(negedge clk);
    bus.opdata1_i = 32'd5;
    bus.opdata2_i = 32'd0;
    bus.start_i   = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("annul_end_pre", 64'(bus.ready_o), 64'h1);
    bus.annul_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("annul_end_ready", 64'(bus.ready_o), 64'h0);
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    repeat (2) @(negedge clk);

    // Asynchronous reset in END (result nonzero) and mid-BUSY.
    bus.opdata1_i = 32'd100;
    bus.opdata2_i = 32'd7;
    bus.start_i   = 1'b1;
    repeat (34) @(posedge clk);
    @(negedge clk);
    check("pre_rst_result", bus.result_o, 64'h00000002_0000000E);
    #1 resetn = 1'b0;
    #1;
    check("async_rst_result", bus.result_o, 64'h0);
    check("async_rst_ready", 64'(bus.ready_o), 64'h0);
    bus.start_i = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    bus.start_i = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    #1 resetn = 1'b0;
    #1;
    check("busy_rst_ready", 64'(bus.ready_o), 64'h0);
    check("busy_rst_result", bus.result_o, 64'h0);
    bus.start_i = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    do_div("u1_1",     1'b0, 32'd1,          32'd1,          34,       64'h00000000_00000001);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
